// File: rtl/muldiv_controller_if.sv
// Execute-stage handshake and HI/LO result bundle for muldiv_controller.
// The pipeline drives the master modport and the controller implements the slave.
interface muldiv_controller_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  StartMultE;
    logic                  StartDivE;
    logic                  SignedE;
    logic [DATA_WIDTH-1:0] SrcAE;
    logic [DATA_WIDTH-1:0] SrcBE;
    logic                  WriteHiE;
    logic                  WriteLoE;
    logic                  HiLoUseD;
    logic [DATA_WIDTH-1:0] Hi;
    logic [DATA_WIDTH-1:0] Lo;
    logic                  Busy;
    logic                  HiLoStallD;

    modport master (
        output StartMultE, StartDivE, SignedE, SrcAE, SrcBE,
        output WriteHiE, WriteLoE, HiLoUseD,
        input  Hi, Lo, Busy, HiLoStallD
    );

    modport slave (
        input  StartMultE, StartDivE, SignedE, SrcAE, SrcBE,
        input  WriteHiE, WriteLoE, HiLoUseD,
        output Hi, Lo, Busy, HiLoStallD
    );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative 32-cycle multiply/divide sequencer owning the HI/LO register pair.
// Define MULDIV_DIV_EN to compile in the restoring-divide path; otherwise multiply only.
module muldiv_controller #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input logic                CLK,
    input logic                RST,
    muldiv_controller_if.slave bus
);
    localparam int unsigned W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W:0]         acc;      // {carry/rem-top, upper word, lower word}
    logic [W-1:0]         opb;      // multiplicand or divisor
    logic                 neg_lo;   // negate product or quotient in FIXUP
    logic                 busy;
    logic [W-1:0]         hi;
    logic [W-1:0]         lo;

    logic                 start_div;
    logic                 neg_a;
    logic                 neg_b;
    logic [W-1:0]         abs_a;
    logic [W-1:0]         abs_b;
    logic [W:0]           mul_sum;
    logic [2*W:0]         mul_next;
    logic [2*W-1:0]       prod_fix;

`ifdef MULDIV_DIV_EN
    logic                 is_div;
    logic                 neg_hi;   // negate remainder in FIXUP
    logic [W:0]           rem_sh;
    logic [W:0]           diff;
    logic [2*W:0]         div_next;
    logic [W-1:0]         quo_fix;
    logic [W-1:0]         rem_fix;

    assign start_div = bus.StartDivE;
`else
    assign start_div = 1'b0;
`endif

    always_comb begin
        neg_a    = bus.SignedE & bus.SrcAE[W-1];
        neg_b    = bus.SignedE & bus.SrcBE[W-1];
        abs_a    = neg_a ? -bus.SrcAE : bus.SrcAE;
        abs_b    = neg_b ? -bus.SrcBE : bus.SrcBE;

        mul_sum  = acc[2*W:W] + {1'b0, opb};
        mul_next = acc[0] ? {1'b0, mul_sum, acc[W-1:1]} : {1'b0, acc[2*W:1]};
        prod_fix = neg_lo ? -acc[2*W-1:0] : acc[2*W-1:0];

`ifdef MULDIV_DIV_EN
        // Remainder never reaches the divisor, so its top bit is always clear here.
        rem_sh   = {acc[2*W-1:W], acc[W-1]};
        diff     = rem_sh - {1'b0, opb};
        div_next = diff[W] ? {rem_sh, acc[W-2:0], 1'b0} : {diff, acc[W-2:0], 1'b1};
        quo_fix  = neg_lo ? -acc[W-1:0]   : acc[W-1:0];
        rem_fix  = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_lo <= 1'b0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.StartMultE) begin
                        acc    <= {{(W+1){1'b0}}, abs_b};
                        opb    <= abs_a;
                        neg_lo <= neg_a ^ neg_b;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
`ifdef MULDIV_DIV_EN
                        is_div <= 1'b0;
                        neg_hi <= 1'b0;
`endif
                    end
`ifdef MULDIV_DIV_EN
                    else if (start_div) begin
                        is_div <= 1'b1;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (bus.SrcBE == '0) begin
                            // Preload the raw result so FIXUP publishes it without sign correction.
                            acc    <= {1'b0, bus.SrcAE, {W{1'b1}}};
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                            state  <= FIXUP;
                        end else begin
                            acc    <= {{(W+1){1'b0}}, abs_a};
                            opb    <= abs_b;
                            neg_lo <= neg_a ^ neg_b;
                            neg_hi <= neg_a;
                            state  <= CALC;
                        end
                    end
`endif
                    else begin
                        if (bus.WriteHiE) hi <= bus.SrcAE;
                        if (bus.WriteLoE) lo <= bus.SrcAE;
                    end
                end
                CALC: begin
`ifdef MULDIV_DIV_EN
                    acc <= is_div ? div_next : mul_next;
`else
                    acc <= mul_next;
`endif
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(W - 1)) state <= FIXUP;
                end
                FIXUP: begin
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else
`endif
                    begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Hi         = hi;
    assign bus.Lo         = lo;
    assign bus.Busy       = busy;
    assign bus.HiLoStallD = bus.HiLoUseD & (busy | bus.StartMultE | start_div);
endmodule

// File: tb/tb_muldiv_controller.sv
// Directed plus randomized bench for muldiv_controller against a plain-arithmetic HI/LO model.
// Honours MULDIV_DIV_EN the same way as the design.
module tb_muldiv_controller;
    logic        CLK;
    logic        RST;
    int          n_cmp;
    int          n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    muldiv_controller_if #(.DATA_WIDTH(32)) bus ();

    muldiv_controller #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural result {HI, LO} of one MULT*/DIV*.
    function automatic logic [63:0] ref_op(input bit is_div, input logic [31:0] a,
                                           input logic [31:0] b, input bit s);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            if (s) p = 64'(sa * sb);
            else   p = {32'b0, a} * {32'b0, b};
            return p;
        end
        if (b == 32'b0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic idle_inputs();
        bus.StartMultE = 1'b0;
        bus.StartDivE  = 1'b0;
        bus.SignedE    = 1'b0;
        bus.SrcAE      = '0;
        bus.SrcBE      = '0;
        bus.WriteHiE   = 1'b0;
        bus.WriteLoE   = 1'b0;
        bus.HiLoUseD   = 1'b0;
    endtask

    // mode: 0 = multiply, 1 = divide, 2 = both strobes (multiply must win).
    // glitch: pulse a protocol-violating start strobe mid-operation.
    task automatic do_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input bit glitch, input string tag);
        bit          is_div;
        bit          runs;
        logic [63:0] r;
        int          exp_cycles;
        int          cycles;
        is_div     = (mode == 1);
        runs       = !is_div || DIV_EN;
        r          = ref_op(is_div, a, b, s);
        exp_cycles = !runs ? 0 : ((is_div && b == 32'b0) ? 1 : 33);

        bus.StartMultE = (mode != 1);
        bus.StartDivE  = (mode != 0);
        bus.SrcAE      = a;
        bus.SrcBE      = b;
        bus.SignedE    = s;
        bus.HiLoUseD   = 1'b1;
        bus.WriteHiE   = (mode != 1);
        bus.WriteLoE   = (mode == 0);
        #1;
        check({tag, ":stall_start"}, {31'b0, bus.HiLoStallD}, {31'b0, runs});
        @(posedge CLK); #1;
        bus.StartMultE = 1'b0;
        bus.StartDivE  = 1'b0;
        bus.WriteHiE   = 1'b0;
        bus.WriteLoE   = 1'b0;

        cycles = 0;
        while (bus.Busy === 1'b1 && cycles < 40) begin
            bus.StartMultE = glitch && (cycles == 5);
            bus.SrcAE      = $urandom;
            bus.SrcBE      = $urandom;
            bus.SignedE    = 1'($urandom_range(0, 1));
            #1;
            check({tag, ":hold_hi"}, bus.Hi, m_hi);
            check({tag, ":hold_lo"}, bus.Lo, m_lo);
            check({tag, ":stall_busy"}, {31'b0, bus.HiLoStallD}, 32'd1);
            cycles++;
            @(posedge CLK); #1;
        end
        bus.StartMultE = 1'b0;
        check({tag, ":busy_cycles"}, 32'(cycles), 32'(exp_cycles));

        if (runs) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        check({tag, ":hi"}, bus.Hi, m_hi);
        check({tag, ":lo"}, bus.Lo, m_lo);
        check({tag, ":busy_end"}, {31'b0, bus.Busy}, 32'd0);
        check({tag, ":stall_end"}, {31'b0, bus.HiLoStallD}, 32'd0);
        bus.HiLoUseD = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_hi  = '0;
        m_lo  = '0;
        idle_inputs();
        RST = 1'b0;
        #2;
        check("reset_hi", bus.Hi, 32'h0);
        check("reset_lo", bus.Lo, 32'h0);
        check("reset_busy", {31'b0, bus.Busy}, 32'd0);
        check("reset_stall", {31'b0, bus.HiLoStallD}, 32'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK); #1;

        do_op(0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, "mult_signed");
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mult_unsigned");
        do_op(1, 32'd100, 32'd7, 1'b0, 1'b0, "div_100_7");
        do_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_m7_2");
        do_op(1, 32'h0000_1234, 32'd0, 1'b0, 1'b0, "div_by_zero");
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_min_m1");
        do_op(1, 32'h8000_0000, 32'd0, 1'b1, 1'b0, "div0_signed");

        bus.SrcAE    = 32'hA5A5_A5A5;
        bus.WriteLoE = 1'b1;
        @(posedge CLK); #1;
        bus.WriteLoE = 1'b0;
        m_lo = 32'hA5A5_A5A5;
        check("mtlo", bus.Lo, m_lo);
        check("mtlo_hi_kept", bus.Hi, m_hi);
        bus.SrcAE    = 32'h5A5A_0F0F;
        bus.WriteHiE = 1'b1;
        @(posedge CLK); #1;
        bus.WriteHiE = 1'b0;
        m_hi = 32'h5A5A_0F0F;
        check("mthi", bus.Hi, m_hi);
        check("mthi_lo_kept", bus.Lo, m_lo);

        do_op(2, $urandom, $urandom, 1'b1, 1'b1, "mult_wins");

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? $urandom_range(1, 20) : $urandom;
            if (i % 4 == 1) ra = -$urandom_range(1, 1000);
            do_op(i % 2, ra, rb, 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        bus.StartMultE = 1'b1;
        bus.SignedE    = 1'b0;
        bus.SrcAE      = $urandom;
        bus.SrcBE      = $urandom;
        @(posedge CLK); #1;
        bus.StartMultE = 1'b0;
        repeat (10) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("abort_busy", {31'b0, bus.Busy}, 32'd0);
        check("abort_hi", bus.Hi, 32'h0);
        check("abort_lo", bus.Lo, 32'h0);
        check("abort_stall", {31'b0, bus.HiLoStallD}, 32'd0);
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        do_op(0, $urandom, $urandom, 1'b1, 1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
